// File: rtl/branch_update_sched_pkg.sv
// Shared branch-predictor definitions: default widths, the update bundle
// exchanged with branch_pred, and the scheduler's two sequencing states.
`ifndef SYS_DEFS_MACROS
`define SYS_DEFS_MACROS
`define N 2
`define XLEN 32
`define TABLE_ENTRIES 32
`endif

package sys_defs;

  typedef struct packed {
    logic [`XLEN-1:0] pc;
    logic             taken;
    logic [`XLEN-1:0] target;
  } BR_UPD;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } BR_SCHED_STATE;

endpackage

// File: rtl/branch_update_sched_compact.sv
// Lane compactor: popcount of the valid lanes plus each lane's slot offset
// (exclusive prefix sum), so valid lanes pack densely from the FIFO tail.
module br_compact
  import sys_defs::*;
#(
  parameter int N = `N
) (
  input  logic [N-1:0]                     valid_i,
  output logic [$clog2(N+1)-1:0]           count_o,
  output logic [N-1:0][$clog2(N+1)-1:0]    offset_o
);

  localparam int CW = $clog2(N + 1);

  always_comb begin
    logic [CW-1:0] runSum;
    runSum   = '0;
    offset_o = '0;
    for (int i = 0; i < N; i++) begin
      offset_o[i] = runSum;
      runSum      = runSum + CW'(valid_i[i]);
    end
    count_o = runSum;
  end

endmodule

// File: rtl/branch_update_sched.sv
// Update scheduler for branch_pred: buffers up to N resolved branches per cycle
// in a FIFO, drains one per cycle to the update port, and sweeps a table clear.
module branch_update_sched
  import sys_defs::*;
#(
  parameter int N             = `N,
  parameter int XLEN          = `XLEN,
  parameter int DEPTH         = 8,
  parameter int TABLE_ENTRIES = `TABLE_ENTRIES
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N-1:0]                     res_valid,
  input  logic [N-1:0][XLEN-1:0]           res_pc,
  input  logic [N-1:0]                     res_taken,
  input  logic [N-1:0][XLEN-1:0]           res_target,
  output logic                             res_stall,
  input  logic                             clear_req,
  output logic                             clr_valid,
  output logic [$clog2(TABLE_ENTRIES)-1:0] clr_idx,
  output logic                             upd_valid,
  output logic [XLEN-1:0]                  upd_pc,
  output logic [XLEN-1:0]                  upd_target,
  output logic                             upd_taken,
  input  logic                             upd_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(TABLE_ENTRIES);
  localparam int LW = $clog2(N + 1);

  BR_SCHED_STATE          state_q;
  logic [IW-1:0]          clrCnt_q;
  logic [PW-1:0]          head_q, head_d;
  logic [PW-1:0]          tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  BR_UPD                  fifo_q [DEPTH];

  logic [LW-1:0]          laneCount;
  logic [N-1:0][LW-1:0]   laneOffset;
  logic [LW-1:0]          enqNum;
  logic                   enq;
  logic                   deq;
  BR_UPD                  headEntry;

  br_compact #(.N(N)) u_compact (
    .valid_i  (res_valid),
    .count_o  (laneCount),
    .offset_o (laneOffset)
  );

  // Stall looks only at registered state so upstream never sees a loop through res_*.
  assign res_stall = (state_q == CLEAR) || ((DEPTH - int'(count_q)) < N);
  assign clr_valid = (state_q == CLEAR);
  assign clr_idx   = clrCnt_q;
  assign upd_valid = (state_q == RUN) && (count_q != '0);

  assign headEntry  = fifo_q[head_q];
  assign upd_pc     = headEntry.pc;
  assign upd_taken  = headEntry.taken;
  assign upd_target = headEntry.target;

  // A clear request in RUN overrides both the enqueue and the dequeue of its cycle.
  assign enq    = !res_stall && !clear_req;
  assign deq    = upd_valid && upd_ready && !clear_req;
  assign enqNum = enq ? laneCount : '0;

  assign head_d  = head_q + PW'(deq);
  assign tail_d  = tail_q + PW'(enqNum);
  assign count_d = count_q + CW'(enqNum) - CW'(deq);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= CLEAR;
      clrCnt_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clrCnt_q == IW'(TABLE_ENTRIES - 1)) begin
            state_q  <= RUN;
            clrCnt_q <= '0;
          end else begin
            clrCnt_q <= clrCnt_q + IW'(1);
          end
        end
        RUN: begin
          if (clear_req) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
          end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Payload storage needs no reset; count gates every read of it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (enq && res_valid[i]) begin
        fifo_q[tail_q + PW'(laneOffset[i])] <= '{pc:     res_pc[i],
                                                  taken:  res_taken[i],
                                                  target: res_target[i]};
      end
    end
  end

endmodule

// File: tb/tb_branch_update_sched.sv
// Self-checking bench for branch_update_sched: directed scenarios plus a
// randomized run checked against a queue-based model of the scheduler.
module tb_branch_update_sched;

  localparam int N     = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int TE    = 32;
  localparam int IW    = $clog2(TE);

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [N-1:0]           res_valid = '0;
  logic [N-1:0][XLEN-1:0] res_pc = '0;
  logic [N-1:0]           res_taken = '0;
  logic [N-1:0][XLEN-1:0] res_target = '0;
  logic                   res_stall;
  logic                   clear_req = 1'b0;
  logic                   clr_valid;
  logic [IW-1:0]          clr_idx;
  logic                   upd_valid;
  logic [XLEN-1:0]        upd_pc;
  logic [XLEN-1:0]        upd_target;
  logic                   upd_taken;
  logic                   upd_ready = 1'b0;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t modelQ[$];
  bit     modelClear = 1'b1;
  int     modelIdx   = 0;
  int     tests      = 0;
  int     fails      = 0;

  branch_update_sched #(.N(N), .XLEN(XLEN), .DEPTH(DEPTH), .TABLE_ENTRIES(TE)) dut (
    .clock      (clock),
    .reset      (reset),
    .res_valid  (res_valid),
    .res_pc     (res_pc),
    .res_taken  (res_taken),
    .res_target (res_target),
    .res_stall  (res_stall),
    .clear_req  (clear_req),
    .clr_valid  (clr_valid),
    .clr_idx    (clr_idx),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit expStall();
    return modelClear || ((DEPTH - modelQ.size()) < N);
  endfunction

  function automatic bit expUpdValid();
    return !modelClear && (modelQ.size() > 0);
  endfunction

  // One clock edge: the model consumes the inputs that were presented before it.
  task automatic advance();
    int sz;
    @(posedge clock);
    if (!reset) begin
      modelQ.delete();
      modelClear = 1'b1;
      modelIdx   = 0;
    end else if (modelClear) begin
      modelIdx++;
      if (modelIdx == TE) begin
        modelClear = 1'b0;
        modelIdx   = 0;
      end
    end else if (clear_req) begin
      modelQ.delete();
      modelClear = 1'b1;
      modelIdx   = 0;
    end else begin
      sz = modelQ.size();
      if (upd_ready && sz > 0) void'(modelQ.pop_front());
      if (DEPTH - sz >= N) begin
        for (int i = 0; i < N; i++) begin
          if (res_valid[i]) modelQ.push_back('{res_pc[i], res_taken[i], res_target[i]});
        end
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [XLEN-1:0] pc0,
                               input logic [XLEN-1:0] pc1);
    res_valid     = v;
    res_pc[0]     = pc0;
    res_pc[1]     = pc1;
    res_taken     = N'($urandom);
    res_target[0] = $urandom;
    res_target[1] = $urandom;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) advance();
    tests++; if (clr_valid !== 1'b1) begin fails++; $display("[TB] FAIL reset clr_valid: got %b want 1", clr_valid); end
    tests++; if (clr_idx !== '0) begin fails++; $display("[TB] FAIL reset clr_idx: got %0d want 0", clr_idx); end
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset upd_valid: got %b want 0", upd_valid); end
    tests++; if (res_stall !== 1'b1) begin fails++; $display("[TB] FAIL reset res_stall: got %b want 1", res_stall); end
  endtask

  task automatic test_sweep();
    reset = 1'b1;
    applyStimulus(2'b11, 32'h100, 32'h104);
    for (int i = 0; i < TE; i++) begin
      tests++; if (clr_valid !== 1'b1 || clr_idx !== IW'(i)) begin
        fails++; $display("[TB] FAIL sweep idx: got valid=%b idx=%0d want valid=1 idx=%0d", clr_valid, clr_idx, i);
      end
      tests++; if (res_stall !== 1'b1 || upd_valid !== 1'b0) begin
        fails++; $display("[TB] FAIL sweep stall: got stall=%b upd_valid=%b want 1/0", res_stall, upd_valid);
      end
      advance();
    end
    applyStimulus(2'b00, 0, 0);
    tests++; if (clr_valid !== 1'b0 || res_stall !== 1'b0 || upd_valid !== 1'b0) begin
      fails++; $display("[TB] FAIL sweep end: got clr=%b stall=%b upd=%b want 0/0/0", clr_valid, res_stall, upd_valid);
    end
  endtask

  task automatic test_compaction();
    logic [XLEN-1:0] want [3];
    want[0] = 32'h40; want[1] = 32'h80; want[2] = 32'h84;
    upd_ready = 1'b1;
    applyStimulus(2'b10, 32'hdead, 32'h40);
    advance();
    applyStimulus(2'b11, 32'h80, 32'h84);
    for (int k = 0; k < 3; k++) begin
      tests++; if (upd_valid !== 1'b1 || upd_pc !== want[k]) begin
        fails++; $display("[TB] FAIL compaction %0d: got valid=%b pc=%h want 1 pc=%h", k, upd_valid, upd_pc, want[k]);
      end
      advance();
      applyStimulus(2'b00, 0, 0);
    end
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("[TB] FAIL compaction drain: got upd_valid=%b want 0", upd_valid); end
  endtask

  task automatic test_backpressure();
    upd_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(2'b11, 32'h1000 + 8 * c, 32'h1004 + 8 * c);
      tests++; if (res_stall !== (c >= 4)) begin
        fails++; $display("[TB] FAIL backpressure stall %0d: got %b want %b", c, res_stall, (c >= 4));
      end
      if (c > 0) begin
        tests++; if (upd_valid !== 1'b1 || upd_pc !== 32'h1000) begin
          fails++; $display("[TB] FAIL backpressure head %0d: got valid=%b pc=%h want 1 pc=1000", c, upd_valid, upd_pc);
        end
      end
      advance();
    end
    applyStimulus(2'b00, 0, 0);
    upd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests++; if (upd_valid !== 1'b1 || upd_pc !== 32'h1000 + 4 * k || res_stall !== (k < 2)) begin
        fails++; $display("[TB] FAIL backpressure drain %0d: got valid=%b pc=%h stall=%b want 1 pc=%h stall=%b",
                          k, upd_valid, upd_pc, res_stall, 32'h1000 + 4 * k, (k < 2));
      end
      advance();
    end
    tests++; if (upd_valid !== 1'b0 || res_stall !== 1'b0) begin
      fails++; $display("[TB] FAIL backpressure empty: got valid=%b stall=%b want 0/0", upd_valid, res_stall);
    end
  endtask

  task automatic test_wrap();
    upd_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(2'b01, 32'h2000 + 4 * c, 32'h0);
      if (c > 0) begin
        tests++; if (upd_valid !== 1'b1 || upd_pc !== 32'h2000 + 4 * (c - 1)) begin
          fails++; $display("[TB] FAIL wrap %0d: got valid=%b pc=%h want 1 pc=%h", c, upd_valid, upd_pc, 32'h2000 + 4 * (c - 1));
        end
      end
      advance();
    end
    applyStimulus(2'b00, 0, 0);
    tests++; if (upd_pc !== 32'h2000 + 4 * 19) begin fails++; $display("[TB] FAIL wrap last: got pc=%h want %h", upd_pc, 32'h2000 + 4 * 19); end
    advance();
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("[TB] FAIL wrap drain: got upd_valid=%b want 0", upd_valid); end
  endtask

  task automatic test_flush();
    upd_ready = 1'b0;
    applyStimulus(2'b11, 32'h3000, 32'h3004); advance();
    applyStimulus(2'b11, 32'h3008, 32'h300c); advance();
    applyStimulus(2'b01, 32'h3010, 32'h0);    advance();
    applyStimulus(2'b11, 32'h3014, 32'h3018);
    upd_ready = 1'b1;
    clear_req = 1'b1;
    tests++; if (upd_valid !== 1'b1 || upd_pc !== 32'h3000) begin
      fails++; $display("[TB] FAIL flush pending: got valid=%b pc=%h want 1 pc=3000", upd_valid, upd_pc);
    end
    advance();
    clear_req = 1'b0;
    applyStimulus(2'b00, 0, 0);
    tests++; if (clr_valid !== 1'b1 || clr_idx !== '0 || upd_valid !== 1'b0 || res_stall !== 1'b1) begin
      fails++; $display("[TB] FAIL flush start: got clr=%b idx=%0d upd=%b stall=%b want 1/0/0/1", clr_valid, clr_idx, upd_valid, res_stall);
    end
    for (int i = 1; i < TE; i++) begin
      clear_req = (i == 10);
      advance();
      tests++; if (clr_valid !== 1'b1 || clr_idx !== IW'(i)) begin
        fails++; $display("[TB] FAIL flush sweep: got valid=%b idx=%0d want 1 idx=%0d", clr_valid, clr_idx, i);
      end
    end
    clear_req = 1'b0;
    advance();
    tests++; if (clr_valid !== 1'b0 || upd_valid !== 1'b0 || res_stall !== 1'b0) begin
      fails++; $display("[TB] FAIL flush end: got clr=%b upd=%b stall=%b want 0/0/0", clr_valid, upd_valid, res_stall);
    end
  endtask

  task automatic test_async_reset();
    int budget;
    upd_ready = 1'b0;
    applyStimulus(2'b11, 32'h4000, 32'h4004);
    advance();
    applyStimulus(2'b00, 0, 0);
    tests++; if (upd_valid !== 1'b1) begin fails++; $display("[TB] FAIL async nonempty: got upd_valid=%b want 1", upd_valid); end
    #2 reset = 1'b0;
    #1;
    tests++; if (clr_valid !== 1'b1 || clr_idx !== '0 || upd_valid !== 1'b0 || res_stall !== 1'b1) begin
      fails++; $display("[TB] FAIL async run reset: got clr=%b idx=%0d upd=%b stall=%b want 1/0/0/1", clr_valid, clr_idx, upd_valid, res_stall);
    end
    advance();
    reset = 1'b1;
    budget = 0;
    while (clr_idx !== IW'(13) && budget < 100) begin
      advance();
      budget++;
    end
    tests++; if (budget >= 100) begin fails++; $display("[TB] FAIL async wait: clr_idx=%0d never reached 13", clr_idx); end
    #2 reset = 1'b0;
    #1;
    tests++; if (clr_valid !== 1'b1 || clr_idx !== '0 || upd_valid !== 1'b0 || res_stall !== 1'b1) begin
      fails++; $display("[TB] FAIL async mid-sweep: got clr=%b idx=%0d upd=%b stall=%b want 1/0/0/1", clr_valid, clr_idx, upd_valid, res_stall);
    end
    advance();
    advance();
    reset = 1'b1;
    for (int i = 0; i < TE; i++) begin
      tests++; if (clr_idx !== IW'(i)) begin fails++; $display("[TB] FAIL async restart: got idx=%0d want %0d", clr_idx, i); end
      advance();
    end
    tests++; if (clr_valid !== 1'b0 || res_stall !== 1'b0) begin
      fails++; $display("[TB] FAIL async end: got clr=%b stall=%b want 0/0", clr_valid, res_stall);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      tests++; if (clr_valid !== modelClear || (modelClear && clr_idx !== IW'(modelIdx))) begin
        fails++; $display("[TB] FAIL random clr %0d: got valid=%b idx=%0d want valid=%b idx=%0d", c, clr_valid, clr_idx, modelClear, modelIdx);
      end
      tests++; if (res_stall !== expStall() || upd_valid !== expUpdValid()) begin
        fails++; $display("[TB] FAIL random flags %0d: got stall=%b upd=%b want stall=%b upd=%b", c, res_stall, upd_valid, expStall(), expUpdValid());
      end
      if (expUpdValid()) begin
        tests++; if (upd_pc !== modelQ[0].pc || upd_taken !== modelQ[0].taken || upd_target !== modelQ[0].target) begin
          fails++; $display("[TB] FAIL random head %0d: got pc=%h t=%b tgt=%h want pc=%h t=%b tgt=%h", c,
                            upd_pc, upd_taken, upd_target, modelQ[0].pc, modelQ[0].taken, modelQ[0].target);
        end
      end
      applyStimulus(N'($urandom), $urandom, $urandom);
      upd_ready = ($urandom_range(0, 3) != 0);
      clear_req = ($urandom_range(0, 99) == 0);
      advance();
    end
    clear_req = 1'b0;
    applyStimulus(2'b00, 0, 0);
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_compaction();
    test_backpressure();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_update_sched.md
# branch_update_sched

Sequencer and update scheduler for the branch predictor. It accepts up to `N` resolved-branch outcomes per cycle from the execute/CDB lanes and buffers them in a FIFO. It drains them one per cycle into the predictor's single update port. It also sequences a full predictor-table clear after reset or on request. It sits between the CDB branch-resolution lanes and `branch_pred`.

## Interface
Parameters:
- `N`, `` `N ``, superscalar width (number of resolution lanes)
- `XLEN`, `` `XLEN ``, address width
- `DEPTH`, 8, FIFO entries; power of two, ≥ `N`
- `TABLE_ENTRIES`, 32, predictor table rows to clear; power of two

Ports:
- `clock`  input  1  single clock; all state updates on posedge
- `reset`  input  1  asynchronous, active-low (0 = in reset)
- `res_valid`  input  `N`  lane i carries a resolved branch
- `res_pc`  input  `N`×`XLEN`  branch PC per lane
- `res_taken`  input  `N`  actual direction per lane
- `res_target`  input  `N`×`XLEN`  actual target per lane
- `res_stall`  output  1  upstream must hold lanes; inputs are ignored while high
- `clear_req`  input  1  request a full table clear
- `clr_valid`  output  1  clear-write strobe to predictor
- `clr_idx`  output  `$clog2(TABLE_ENTRIES)`  row being cleared
- `upd_valid`  output  1  FIFO head is presented for update
- `upd_pc`, `upd_target`  output  `XLEN`  head fields
- `upd_taken`  output  1  head direction
- `upd_ready`  input  1  predictor accepts the update this cycle

## Operation
- FSM has two states: `CLEAR` and `RUN`. The reset state is `CLEAR`.
- In `CLEAR`:
  - `clr_valid` = 1 and `clr_idx` = counter.
  - The counter increments each cycle, unconditionally.
  - When `clr_idx` == `TABLE_ENTRIES-1`, the next state is `RUN` and the counter returns to 0.
  - `res_stall` = 1 and `upd_valid` = 0.
- In `RUN`:
  - `clr_valid` = 0.
  - `res_stall` = (DEPTH − count) < N. It is combinational from the registered count, so it never depends on the current `res_valid`.
- Enqueue happens when in `RUN` and `!res_stall`.
  - All lanes with `res_valid` set are written compacted into consecutive slots from the tail, in ascending lane order.
  - Tail advances by popcount(`res_valid`).
- Dequeue happens when `upd_valid && upd_ready`. Head advances by 1.
  - `upd_valid` = (state==RUN) && count≠0.
  - Head fields are driven directly from the FIFO slot at the head pointer.
- Count is updated as count + enq − deq. Enqueue and dequeue in the same cycle are allowed.
- Pointer and count rules:
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Count is `$clog2(DEPTH+1)` bits and never exceeds `DEPTH`, guaranteed by the stall rule.
- `clear_req` behaviour:
  - In `RUN`, a `clear_req` sampled high takes priority over that cycle's enqueue and dequeue. The FIFO is flushed (count, head, tail ← 0) and the next state is `CLEAR`.
  - In `CLEAR`, `clear_req` is ignored; the sweep is not restarted.
- Reset asserted at any time, including mid-clear or with a non-empty FIFO:
  - Immediately: state=`CLEAR`, counter=0, head=tail=count=0.
  - Outputs during reset: `clr_valid`=1, `clr_idx`=0, `upd_valid`=0, `res_stall`=1.

## Timing
- The clear sweep lasts exactly `TABLE_ENTRIES` cycles after reset deassertion. `res_stall` drops in the first `RUN` cycle.
- Enqueue-to-update latency is 1 cycle: an entry written at edge t appears on `upd_*` in the cycle after t.
- With `upd_ready`=1 continuously, there is 1 update per cycle and the FIFO order is preserved.
- With `upd_ready`=0, the `upd_*` outputs hold stable until accepted.
- `clear_req` high at edge t: `clr_valid`=1 with `clr_idx`=0 in the cycle after t. Entries pending at t are lost, and a dequeue in that same cycle does not count as accepted.
- No combinational path exists from `res_*` or `upd_ready` to `res_stall`. There is a combinational path from state/count to the `upd_*` outputs only.

## Structure
- Shared `sys_defs` package holds:
  - the `BR_UPD` struct {pc, taken, target}, used for the FIFO slot and the predictor update bundle;
  - the `BR_SCHED_STATE` enum {CLEAR, RUN}.
- `N`, `XLEN` and `TABLE_ENTRIES` defaults come from `sys_defs` macros.
- Sub-module `br_compact` is a combinational lane compactor. It outputs popcount plus the per-lane slot offset (exclusive prefix sum of `res_valid`). `branch_update_sched` instantiates it once.

## Test plan
- **Reset and clear sweep:** deassert `reset` with `TABLE_ENTRIES`=32 → `clr_idx` runs 0..31 over 32 cycles, then `clr_valid`=0 and `res_stall`=0. During the sweep, lanes driven valid are not enqueued.
- **Compaction:** N=2, `res_valid`=2'b10 with lane1 pc=0x40, then 2'b11 with lane0 pc=0x80 and lane1 pc=0x84. With `upd_ready`=1 the updates are 0x40, 0x80, 0x84 on consecutive cycles.
- **Backpressure:** hold `upd_ready`=0 and enqueue 2 per cycle with DEPTH=8 → `res_stall` rises when count=7 or 8 (free < 2). The head is stable at the first PC. Releasing `upd_ready` drains all 8 entries in order, and `res_stall` falls once free ≥ 2.
- **Wrap-around:** sustain 1 enqueue and 1 dequeue per cycle for 20 cycles → count stays 1, and the PC sequence is preserved across the pointer wrap.
- **Flush with `clear_req`:** assert `clear_req` with 5 entries pending and `upd_ready`=1 → the next cycle shows `clr_valid`=1, `clr_idx`=0, `upd_valid`=0. After 32 cycles the state returns to `RUN` with count 0.
- **Async reset mid-operation:** pull `reset` low mid-sweep at `clr_idx`=13, between edges → the outputs go to reset values immediately. After release the sweep restarts at 0.
